md_unit_ctrl: RTL and testbench

//  Multiply/divide unit with its sequencing controller for the 5-stage MIPS pipeline.

---
 rtl/md_unit_ctrl_pkg.sv | 22 ++
 rtl/md_unit_ctrl_arith.sv | 53 +++++
 rtl/md_unit_ctrl.sv | 106 ++++++++++
 tb/tb_md_unit_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, decode helpers.
package md_unit_ctrl_pkg;

  localparam logic [2:0] MdMult  = 3'd0;
  localparam logic [2:0] MdMultu = 3'd1;
  localparam logic [2:0] MdDiv   = 3'd2;
  localparam logic [2:0] MdDivu  = 3'd3;
  localparam logic [2:0] MdMthi  = 3'd4;
  localparam logic [2:0] MdMtlo  = 3'd5;

  typedef enum logic {StIdle, StBusy} md_state_e;

  // True for ops that occupy the unit for multiple cycles.
  function automatic logic is_muldiv(logic [2:0] op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_div(logic [2:0] op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational 32x32 multiply / divide datapath producing the full {hi, lo} result.
module md_unit_ctrl_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic [63:0] smul, umul;
  logic [31:0] abs_a, abs_b, uq, ur, sq, sr, dq, dr;

  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'b0, a} * {32'b0, b};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // Shared unsigned divider; signed ops feed it magnitudes.
  always_comb begin
    dq = '0;
    dr = '0;
    if (b != 32'd0) begin
      if (op == MdDiv) begin
        dq = abs_a / abs_b;
        dr = abs_a % abs_b;
      end else begin
        dq = a / b;
        dr = a % b;
      end
    end
  end

  assign uq = dq;
  assign ur = dr;
  assign sq = (a[31] ^ b[31]) ? (~dq + 32'd1) : dq;
  assign sr = a[31] ? (~dr + 32'd1) : dr;

  // Select the result; divide by zero returns hi=dividend, lo=all ones.
  always_comb begin
    res = '0;
    case (op)
      MdMult:  res = smul;
      MdMultu: res = umul;
      MdDiv:   res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {sr, sq};
      MdDivu:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {ur, uq};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide unit: latency-emulating controller, HI/LO registers, md_stall.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic        mt_E,
  input  logic [2:0]  op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q;
  logic [31:0] rs_q, rt_q, hi_q, lo_q;
  logic [63:0] res;
  logic        load_ops, commit, mt_hi, mt_lo;

  md_unit_ctrl_arith u_arith (
    .op  (op_q),
    .a   (rs_q),
    .b   (rt_q),
    .res (res)
  );

  // Next-state: accept a mul/div in IDLE, count down in BUSY, commit on cnt==0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_ops = 1'b0;
    commit   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_E && is_muldiv(op_E)) begin
          state_d  = StBusy;
          load_ops = 1'b1;
          cnt_d    = is_div(op_E) ? DivLoad : MultLoad;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // mthi/mtlo only take effect in IDLE and lose to a simultaneous start.
  assign mt_hi = (state_q == StIdle) && mt_E && !start_E && (op_E == MdMthi);
  assign mt_lo = (state_q == StIdle) && mt_E && !start_E && (op_E == MdMtlo);

  // State, counter, latched operands and HI/LO; async reset aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_ops) begin
        op_q <= op_E;
        rs_q <= rs_E;
        rt_q <= rt_E;
      end
      if (commit) begin
        hi_q <= res[63:32];
        lo_q <= res[31:0];
      end else begin
        if (mt_hi) hi_q <= rs_E;
        if (mt_lo) lo_q <= rs_E;
      end
    end
  end

  assign busy     = (state_q == StBusy);
  assign md_stall = md_use_D & (start_E | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  a_start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(start_E && busy));
  a_mt_while_busy:    assert property (@(posedge clk) disable iff (!reset) !(mt_E && busy));
  a_mt_with_start:    assert property (@(posedge clk) disable iff (!reset) !(mt_E && start_E));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases plus randomized traffic vs a model.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E, mt_E, md_use_D;
  logic [2:0]  op_E;
  logic [31:0] rs_E, rt_E;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  md_unit_ctrl #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start_E  (start_E),
    .mt_E     (mt_E),
    .op_E     (op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining busy cycles, pending result, architectural HI/LO.
  int          m_rem = 0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  int          busy_cnt, stall_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // MIPS mul/div semantics computed in 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MdMult:  begin p = sa * sb; return p; end
      MdMultu: begin u = {32'b0, a} * {32'b0, b}; return u; end
      MdDiv: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MdDivu: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // One clock: drive at negedge, check md_stall, advance model at posedge, check state.
  task automatic cyc(input logic st, input logic mt, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b, input logic use_d);
    @(negedge clk);
    start_E = st; mt_E = mt; op_E = op; rs_E = a; rt_E = b; md_use_D = use_d;
    #1;
    chk("md_stall", md_stall, use_d & (st | (m_rem > 0)));
    if (md_stall) stall_cnt++;
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) {m_hi, m_lo} = m_pend;
    end else if (st) begin
      m_pend = ref_md(op, a, b);
      m_rem  = (op == MdDiv || op == MdDivu) ? DivN : MultN;
    end else if (mt) begin
      if (op == MdMthi) m_hi = a;
      if (op == MdMtlo) m_lo = a;
    end
    #1;
    chk("busy", busy, m_rem > 0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (busy) busy_cnt++;
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, MdMult, 32'h0, 32'h0, use_d);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] lo_save;

  initial begin
    reset = 1'b0; start_E = 0; mt_E = 0; op_E = MdMult; rs_E = 0; rt_E = 0; md_use_D = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_stall", md_stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // mult signed
    busy_cnt = 0;
    cyc(1'b1, 1'b0, MdMult, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(7, 1'b0);
    chk("mult_busy_len", busy_cnt, MultN);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // multu
    cyc(1'b1, 1'b0, MdMultu, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(6, 1'b0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div signed, divu by zero, overflow case
    busy_cnt = 0;
    cyc(1'b1, 1'b0, MdDiv, -32'sd7, 32'd2, 1'b0);
    idle(11, 1'b0);
    chk("div_busy_len", busy_cnt, DivN);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, MdDivu, 32'd7, 32'd0, 1'b0);
    idle(11, 1'b0);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11, 1'b0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // md_stall spans the start cycle plus every busy cycle
    stall_cnt = 0;
    cyc(1'b1, 1'b0, MdMult, 32'd6, 32'd7, 1'b1);
    idle(8, 1'b1);
    chk("stall_len_mult", stall_cnt, MultN + 1);
    chk("mfhi_after", hi, 32'd0);
    chk("mflo_after", lo, 32'd42);
    stall_cnt = 0;
    cyc(1'b1, 1'b0, MdDivu, 32'd100, 32'd7, 1'b1);
    idle(13, 1'b1);
    chk("stall_len_div", stall_cnt, DivN + 1);
    chk("mfhi_div", hi, 32'd2);

    // mthi in IDLE
    lo_save = lo;
    busy_cnt = 0;
    cyc(1'b0, 1'b1, MdMthi, 32'h1234_5678, 32'h0, 1'b0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_kept", lo, lo_save);
    chk("mthi_nobusy", busy_cnt, 0);
    cyc(1'b0, 1'b1, MdMtlo, 32'hCAFE_F00D, 32'h0, 1'b0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);

    // async reset in the middle of a div
    cyc(1'b1, 1'b0, MdDiv, 32'd1000, 32'd3, 1'b0);
    idle(2, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    m_rem = 0; m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(15, 1'b0);
    chk("arst_hi_stays", hi, 32'h0);
    chk("arst_lo_stays", lo, 32'h0);

    // randomized traffic obeying the issue rules
    for (int i = 0; i < 600; i++) begin
      logic st, mt;
      logic [2:0] op;
      st = 1'b0; mt = 1'b0;
      op = 3'($urandom_range(0, 3));
      if (m_rem == 0) begin
        case ($urandom_range(0, 5))
          0, 1: st = 1'b1;
          2: begin mt = 1'b1; op = $urandom_range(0, 1) ? MdMthi : MdMtlo; end
          default: ;
        endcase
      end
      cyc(st, mt, op, pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
